sound_cmd_mailbox: RTL and testbench

//  Sound-side receiver for main-CPU sound commands: each main-CPU write strobe (SNDRQ + CPUDO)

---
 rtl/sound_cmd_mailbox.sv | 176 +++++++++++++++++
 tb/tb_sound_cmd_mailbox.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_cmd_mailbox.sv
// Sound-side command mailbox: queues main-CPU command bytes in a small FIFO,
// presents the head byte to the sound CPU and signals each one with a timed NMI.
module sound_cmd_mailbox #(
    parameter  int DEPTH   = 4,
    parameter  int NMI_LEN = 64,
    parameter  int NMI_GAP = 16,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk48M,
    input  logic          reset,
    input  logic          wr_req,
    input  logic [7:0]    wr_data,
    input  logic          rd_req,
    input  logic          clr_ovr,
    output logic [7:0]    rd_data,
    output logic          nmi_n,
    output logic          pending,
    output logic [AW:0]   count,
    output logic          overrun
);

    localparam int TMAX = (NMI_LEN > NMI_GAP) ? NMI_LEN : NMI_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] LEN_M1 = TW'(NMI_LEN - 1);
    localparam logic [TW-1:0] GAP_M1 = TW'(NMI_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAIT_ACK,
        GAP
    } state_e;

    logic          wr_q, rd_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q, count_d;
    logic          pend_q;
    logic          ovr_q;
    logic [7:0]    rdata_q;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          popped_q, popped_d;

    logic wr_edge, rd_edge;
    logic empty, full;
    logic pop_ok, push_ok;

    assign wr_edge = wr_req & ~wr_q;
    assign rd_edge = ~rd_req & rd_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL);
    // A pop in the same cycle frees the slot a write on a full FIFO needs.
    assign pop_ok  = rd_edge & ~empty;
    assign push_ok = wr_edge & (~full | pop_ok);

    // Occupancy changes only when exactly one of push/pop happens.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Strobe history, pointers, occupancy, sticky overrun and head-byte latch.
    always_ff @(posedge clk48M or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            wr_q    <= wr_req;
            rd_q    <= rd_req;
            count_q <= count_d;
            pend_q  <= (count_d != '0);
            if (pop_ok) begin
                head_q <= head_q + AW'(1);
            end
            if (push_ok) begin
                tail_q <= tail_q + AW'(1);
            end
            if (wr_edge && !push_ok) begin
                ovr_q <= 1'b1;
            end else if (clr_ovr) begin
                ovr_q <= 1'b0;
            end
            if (!empty) begin
                rdata_q <= mem_q[head_q];
            end
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk48M) begin
        if (push_ok) begin
            mem_q[tail_q] <= wr_data;
        end
    end

    // NMI sequencer state and shared pulse/gap timer.
    always_ff @(posedge clk48M or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            popped_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            popped_q <= popped_d;
        end
    end

    // Full-length pulse always; a pop seen during the pulse skips WAIT_ACK.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        popped_d = popped_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d  = ASSERT;
                    tmr_d    = LEN_M1;
                    popped_d = 1'b0;
                end
            end
            ASSERT: begin
                if (pop_ok) begin
                    popped_d = 1'b1;
                end
                if (tmr_q == '0) begin
                    if (popped_q || pop_ok) begin
                        state_d = GAP;
                        tmr_d   = GAP_M1;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            WAIT_ACK: begin
                if (pop_ok) begin
                    state_d = GAP;
                    tmr_d   = GAP_M1;
                end
            end
            GAP: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign nmi_n   = (state_q != ASSERT);
    assign rd_data = rdata_q;
    assign pending = pend_q;
    assign count   = count_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_sound_cmd_mailbox.sv
// Self-checking bench for sound_cmd_mailbox: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_sound_cmd_mailbox;

    localparam int DEPTH = 4;
    localparam int NLEN  = 64;
    localparam int NGAP  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_req = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [7:0] rd_data;
    logic       nmi_n;
    logic       pending;
    logic [2:0] count;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    bit         m_ovr;
    bit         m_wr;
    bit         m_rd;
    int         m_stable;

    sound_cmd_mailbox #(
        .DEPTH  (DEPTH),
        .NMI_LEN(NLEN),
        .NMI_GAP(NGAP)
    ) dut (
        .clk48M (clk),
        .reset  (reset),
        .wr_req (wr_req),
        .wr_data(wr_data),
        .rd_req (rd_req),
        .clr_ovr(clr_ovr),
        .rd_data(rd_data),
        .nmi_n  (nmi_n),
        .pending(pending),
        .count  (count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model applies the same inputs the DUT samples.
    task automatic tick();
        bit we, re, was_empty, pop_ok, push;
        we = wr_req && !m_wr;
        re = !rd_req && m_rd;
        m_wr = wr_req;
        m_rd = rd_req;
        was_empty = (mq.size() == 0);
        pop_ok = re && !was_empty;
        push = we && (mq.size() < DEPTH || pop_ok);
        if (pop_ok) void'(mq.pop_front());
        if (push) mq.push_back(wr_data);
        if (we && !push) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
        if (pop_ok || (was_empty && push)) m_stable = 0;
        else m_stable++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        clr_ovr = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        m_wr = 1'b0;
        m_rd = 1'b0;
        m_stable = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        wr_data = 8'h77;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        tick();
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (nmi_n !== 1'b1) begin
            n_fail++; $display("FAIL rst_nmi: got %b want 1", nmi_n);
        end
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++; $display("FAIL rst_count: got %0d want 0", count);
        end
        n_checks++;
        if (pending !== 1'b0) begin
            n_fail++; $display("FAIL rst_pending: got %b want 0", pending);
        end
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun);
        end
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_rd_data: got %h want 00", rd_data);
        end
        do_reset();
        tick();
    endtask

    task automatic test_single();
        int lo, w;
        wr_data = 8'h5A;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        n_checks++;
        if (count !== 3'd1 || nmi_n !== 1'b1) begin
            n_fail++; $display("FAIL single_e1: got cnt=%0d nmi=%b want 1/1", count, nmi_n);
        end
        tick();
        n_checks++;
        if (nmi_n !== 1'b0) begin
            n_fail++; $display("FAIL single_latency: got nmi=%b want 0", nmi_n);
        end
        lo = 0;
        while (!nmi_n && lo < 300) begin
            lo++;
            tick();
        end
        n_checks++;
        if (lo != NLEN) begin
            n_fail++; $display("FAIL single_pulse: got %0d want %0d", lo, NLEN);
        end
        rd_req = 1'b1;
        tick();
        tick();
        n_checks++;
        if (rd_data !== 8'h5A) begin
            n_fail++; $display("FAIL single_rd: got %h want 5a", rd_data);
        end
        rd_req = 1'b0;
        tick();
        n_checks++;
        if (count !== 3'd0 || pending !== 1'b0) begin
            n_fail++; $display("FAIL single_pop: got cnt=%0d pend=%b want 0/0", count, pending);
        end
        w = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (!nmi_n) w++;
        end
        n_checks++;
        if (w != 0 || rd_data !== 8'h5A) begin
            n_fail++; $display("FAIL single_quiet: got lowcyc=%0d rd=%h want 0/5a", w, rd_data);
        end
    endtask

    task automatic test_pop_during_assert();
        int lo, w;
        wr_data = 8'hC3;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        w = 0;
        while (nmi_n && w < 300) begin
            w++;
            tick();
        end
        lo = 0;
        while (!nmi_n && lo < 300) begin
            lo++;
            if (lo == 5) rd_req = 1'b1;
            if (lo == 8) rd_req = 1'b0;
            tick();
        end
        n_checks++;
        if (lo != NLEN) begin
            n_fail++; $display("FAIL early_pop_pulse: got %0d want %0d", lo, NLEN);
        end
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++; $display("FAIL early_pop_count: got %0d want 0", count);
        end
        w = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (!nmi_n) w++;
        end
        n_checks++;
        if (w != 0) begin
            n_fail++; $display("FAIL early_pop_quiet: got %0d low want 0", w);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) begin
            wr_data = 8'(i);
            wr_req = 1'b1;
            tick();
            wr_req = 1'b0;
            tick();
        end
        n_checks++;
        if (count !== 3'd4 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL ovf_state: got cnt=%0d ovr=%b want 4/1", count, overrun);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            rd_req = 1'b1;
            tick();
            tick();
            n_checks++;
            if (rd_data !== exp) begin
                n_fail++; $display("FAIL ovf_rd%0d: got %h want %h", i, rd_data, exp);
            end
            rd_req = 1'b0;
            tick();
            tick();
        end
        n_checks++;
        if (count !== 3'd0 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drain: got cnt=%0d ovr=%b want 0/1", count, overrun);
        end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clr: got %b want 0", overrun);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp [4];
        exp[0] = 8'h02;
        exp[1] = 8'h03;
        exp[2] = 8'h04;
        exp[3] = 8'h99;
        rd_req = 1'b1;
        tick();
        wr_data = 8'hE1;
        wr_req = 1'b1;
        rd_req = 1'b0;
        tick();
        wr_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if (count !== 3'd1 || rd_data !== 8'hE1) begin
            n_fail++; $display("FAIL sim_empty: got cnt=%0d rd=%h want 1/e1", count, rd_data);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            wr_data = 8'(i);
            wr_req = 1'b1;
            tick();
            wr_req = 1'b0;
            tick();
        end
        rd_req = 1'b1;
        tick();
        wr_data = 8'h99;
        wr_req = 1'b1;
        rd_req = 1'b0;
        tick();
        wr_req = 1'b0;
        n_checks++;
        if (count !== 3'd4 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL sim_full: got cnt=%0d ovr=%b want 4/0", count, overrun);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            tick();
            tick();
            n_checks++;
            if (rd_data !== exp[i]) begin
                n_fail++; $display("FAIL sim_rd%0d: got %h want %h", i, rd_data, exp[i]);
            end
            rd_req = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_held();
        wr_data = 8'h3C;
        wr_req = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        wr_req = 1'b0;
        tick();
        n_checks++;
        if (count !== 3'd1) begin
            n_fail++; $display("FAIL held_wr: got %0d want 1", count);
        end
        rd_req = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        n_checks++;
        if (count !== 3'd1 || rd_data !== 8'h3C) begin
            n_fail++; $display("FAIL held_rd_high: got cnt=%0d rd=%h want 1/3c", count, rd_data);
        end
        rd_req = 1'b0;
        tick();
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++; $display("FAIL held_rd_pop: got %0d want 0", count);
        end
    endtask

    task automatic test_back_to_back();
        int lo, hi, w;
        wr_data = 8'hA1;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        w = 0;
        while (nmi_n && w < 300) begin
            w++;
            tick();
        end
        lo = 0;
        while (!nmi_n && lo < 300) begin
            lo++;
            if (lo == 3) begin
                wr_data = 8'hA2;
                wr_req = 1'b1;
            end
            if (lo == 5) wr_req = 1'b0;
            tick();
        end
        n_checks++;
        if (lo != NLEN || count !== 3'd2) begin
            n_fail++; $display("FAIL b2b_pulse1: got len=%0d cnt=%0d want %0d/2", lo, count, NLEN);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        hi = 0;
        while (nmi_n && hi < 300) begin
            hi++;
            tick();
        end
        n_checks++;
        if (hi < NGAP || hi >= 300) begin
            n_fail++; $display("FAIL b2b_gap: got %0d high want >=%0d", hi, NGAP);
        end
        lo = 0;
        while (!nmi_n && lo < 300) begin
            lo++;
            tick();
        end
        n_checks++;
        if (lo != NLEN || rd_data !== 8'hA2) begin
            n_fail++; $display("FAIL b2b_pulse2: got len=%0d rd=%h want %0d/a2", lo, rd_data, NLEN);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++; $display("FAIL b2b_drain: got %0d want 0", count);
        end
    endtask

    task automatic test_random();
        int run;
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) wr_req = ~wr_req;
            if ($urandom_range(4) == 0) rd_req = ~rd_req;
            clr_ovr = ($urandom_range(15) == 0);
            wr_data = 8'($urandom);
            tick();
            n_checks++;
            if (count !== 3'(mq.size()) || pending !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_count@%0d: got cnt=%0d pend=%b want %0d", i, count, pending, mq.size());
            end
            n_checks++;
            if (overrun !== m_ovr) begin
                n_fail++; $display("FAIL rnd_ovr@%0d: got %b want %b", i, overrun, m_ovr);
            end
            if (m_stable >= 1 && mq.size() > 0) begin
                n_checks++;
                if (rd_data !== mq[0]) begin
                    n_fail++; $display("FAIL rnd_rd@%0d: got %h want %h", i, rd_data, mq[0]);
                end
            end
            if (!nmi_n) begin
                run++;
            end else begin
                if (run != 0) begin
                    n_checks++;
                    if (run != NLEN) begin
                        n_fail++; $display("FAIL rnd_pulse@%0d: got %0d want %0d", i, run, NLEN);
                    end
                end
                run = 0;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        clr_ovr = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        tick();
        test_reset();
        test_single();
        settle(120);
        test_pop_during_assert();
        settle(120);
        test_overflow();
        settle(120);
        test_simultaneous();
        settle(120);
        test_held();
        settle(120);
        test_back_to_back();
        settle(120);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
